// File: rtl/demux_tdm_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
package demux_tdm_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_tdm_slot_reg.sv
// One channel's shadow capture register: synchronous reset, load on enable.
module slot_reg
  import demux_tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the sample until this slot is written again; reset wins over a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demux_tdm.sv
// TDM demultiplexer: locks onto in_sync, collects NCH beats per frame into a
// shadow bank and publishes the completed frame on out_data in one step.
// Optional feature: define DEMUX_TDM_ERRCNT_EN to add a saturating 8-bit
// err_count output that counts sync_err pulses.
//
// state | meaning
// HUNT  | not aligned; beats without in_sync are dropped
// RUN   | aligned; slot tracks the next expected slot in the frame
module demux_tdm
  import demux_tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     in_sync,
  output logic [NCH*WIDTH-1:0]     out_data,
  output logic                     out_frame_valid,
  output logic [$clog2(NCH)-1:0]   slot,
  output logic                     locked,
  output logic                     sync_err
`ifdef DEMUX_TDM_ERRCNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam int SW = $clog2(NCH);

  state_t               state_q, state_nxt;
  logic [SW-1:0]        slot_q, slot_nxt;
  logic [NCH-1:0]       wr_en;
  logic                 frame_done;
  logic                 err;
  logic [WIDTH-1:0]     shadow [NCH];
  logic [NCH*WIDTH-1:0] frame_d;
  logic                 unused_last;

  // Shadow bank, one register per slot.
  for (genvar k = 0; k < NCH; k++) begin : g_shadow
    slot_reg #(.WIDTH(WIDTH)) u_slot_reg (
      .clk  (clk),
      .reset(reset),
      .en   (wr_en[k]),
      .d    (in_data),
      .q    (shadow[k])
    );
  end

  // The last slot's sample goes to out_data straight from in_data on the
  // completing edge, so its shadow copy is never read.
  assign unused_last = ^shadow[NCH-1];

  // Next-state, slot advance, shadow write enables and pulse requests.
  always_comb begin
    state_nxt  = state_q;
    slot_nxt   = slot_q;
    wr_en      = '0;
    frame_done = 1'b0;
    err        = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_sync) begin
            wr_en[0]  = 1'b1;
            slot_nxt  = SW'(1);
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (in_sync) begin
            // Sync restarts the frame; it is only an error mid-frame.
            err      = (slot_q != '0);
            wr_en[0] = 1'b1;
            slot_nxt = SW'(1);
          end else if (slot_q == '0) begin
            err       = 1'b1;
            slot_nxt  = '0;
            state_nxt = HUNT;
          end else begin
            for (int k = 1; k < NCH; k++) begin
              wr_en[k] = (slot_q == SW'(k));
            end
            if (slot_q == SW'(NCH - 1)) begin
              frame_done = 1'b1;
              slot_nxt   = '0;
            end else begin
              slot_nxt = slot_q + SW'(1);
            end
          end
        end
        default: begin
          state_nxt = HUNT;
          slot_nxt  = '0;
        end
      endcase
    end
  end

  // Completed frame: stored slots plus the beat arriving this cycle.
  always_comb begin
    frame_d = '0;
    for (int k = 0; k < NCH - 1; k++) begin
      frame_d[k*WIDTH +: WIDTH] = shadow[k];
    end
    frame_d[(NCH-1)*WIDTH +: WIDTH] = in_data;
  end

  // State, slot, published frame and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= HUNT;
      slot_q          <= '0;
      out_data        <= '0;
      out_frame_valid <= 1'b0;
      sync_err        <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      slot_q          <= slot_nxt;
      out_frame_valid <= frame_done;
      sync_err        <= err;
      if (frame_done) begin
        out_data <= frame_d;
      end
    end
  end

  assign slot   = slot_q;
  assign locked = (state_q == RUN);

`ifdef DEMUX_TDM_ERRCNT_EN
  // Saturating count of framing violations.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_tdm.sv
// Scoreboard bench for demux_tdm (WIDTH=8, NCH=4): the stimulus side runs a
// frame-level model and queues expected frames and errors; a monitor pops
// and compares whenever the DUT pulses.
module tb_demux_tdm;
  import demux_tdm_pkg::*;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SW    = $clog2(NCH);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_sync = 1'b0;
  logic [NCH*WIDTH-1:0] out_data;
  logic                 out_frame_valid;
  logic [SW-1:0]        slot;
  logic                 locked;
  logic                 sync_err;
`ifdef DEMUX_TDM_ERRCNT_EN
  logic [7:0]           err_count;
`endif

  demux_tdm #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sync        (in_sync),
    .out_data       (out_data),
    .out_frame_valid(out_frame_valid),
    .slot           (slot),
    .locked         (locked),
    .sync_err       (sync_err)
`ifdef DEMUX_TDM_ERRCNT_EN
    ,
    .err_count      (err_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errs  = 0;

  // Model state: samples gathered for the current frame, alignment flag.
  logic [WIDTH-1:0]     cur[$];
  bit                   locked_m = 1'b0;
  int                   err_total = 0;
  logic [NCH*WIDTH-1:0] frame_q[$];
  bit                   err_q[$];
  logic [NCH*WIDTH-1:0] exp_out = '0;
  bit                   rst_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: a sync starts a new frame, NCH samples complete it.
  task automatic model_beat(input logic [WIDTH-1:0] d, input bit s);
    logic [NCH*WIDTH-1:0] f;
    if (!locked_m) begin
      if (s) begin
        cur.delete();
        cur.push_back(d);
        locked_m = 1'b1;
      end
    end else if (s) begin
      if (cur.size() != 0) begin
        err_q.push_back(1'b1);
        if (err_total < 255) err_total++;
      end
      cur.delete();
      cur.push_back(d);
    end else if (cur.size() == 0) begin
      err_q.push_back(1'b1);
      if (err_total < 255) err_total++;
      locked_m = 1'b0;
    end else begin
      cur.push_back(d);
      if (cur.size() == NCH) begin
        f = '0;
        for (int k = 0; k < NCH; k++) f[k*WIDTH +: WIDTH] = cur[k];
        frame_q.push_back(f);
        cur.delete();
      end
    end
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input bit s);
    in_data  = d;
    in_sync  = s;
    in_valid = 1'b1;
    model_beat(d, s);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'($urandom_range(0, 1));
    in_data  = WIDTH'($urandom);
    chk("locked", 64'(locked), 64'(locked_m));
    chk("slot", 64'(slot), locked_m ? 64'(cur.size()) : 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_sync  = 1'($urandom_range(0, 1));
      in_data  = WIDTH'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit with_beat);
    reset = 1'b1;
    if (with_beat) begin
      in_valid = 1'b1;
      in_sync  = 1'b1;
      in_data  = WIDTH'($urandom);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    cur.delete();
    locked_m  = 1'b0;
    err_total = 0;
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_slot", 64'(slot), 64'd0);
    chk("rst_frame_valid", 64'(out_frame_valid), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
  endtask

  // Monitor: every pulse must match the head of its queue; out_data must
  // otherwise hold the last published frame (zero after reset).
  always @(negedge clk) begin
    if (out_frame_valid === 1'b1) begin
      if (frame_q.size() == 0) begin
        tests++;
        errs++;
        $display("[TB] FAIL unexpected_frame: got %0h expected no pulse at %0t", out_data, $time);
      end else begin
        exp_out = frame_q.pop_front();
        chk("frame_data", 64'(out_data), 64'(exp_out));
      end
    end
    if (sync_err === 1'b1) begin
      tests++;
      if (err_q.size() == 0) begin
        errs++;
        $display("[TB] FAIL unexpected_sync_err: got pulse expected none at %0t", $time);
      end else begin
        void'(err_q.pop_front());
      end
    end
    if (reset) begin
      rst_pending = 1'b1;
    end else begin
      if (rst_pending) begin
        exp_out     = '0;
        rst_pending = 1'b0;
      end
      chk("out_hold", 64'(out_data), 64'(exp_out));
    end
  end

  initial begin
    int gaps;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Basic frame, one-cycle latency and single-cycle pulse.
    beat(8'hA1, 1'b1);
    beat(8'hB2, 1'b0);
    beat(8'hC3, 1'b0);
    beat(8'hD4, 1'b0);
    chk("basic_data", 64'(out_data), 64'hD4C3B2A1);
    chk("basic_pulse", 64'(out_frame_valid), 64'd1);
    idle(1);
    chk("basic_pulse_end", 64'(out_frame_valid), 64'd0);

    // No sync after reset: nothing locks or publishes.
    do_reset(1'b0);
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    chk("hunt_locked", 64'(locked), 64'd0);
    chk("hunt_out", 64'(out_data), 64'd0);

    // Early sync restarts the frame.
    beat(8'h01, 1'b1);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b1);
    chk("resync_err", 64'(sync_err), 64'd1);
    chk("resync_slot", 64'(slot), 64'd1);
    beat(8'h04, 1'b0);
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    chk("resync_data", 64'(out_data), 64'h06050403);

    // Missing sync at slot 0 drops lock, out_data holds.
    beat(8'h7F, 1'b0);
    chk("lost_err", 64'(sync_err), 64'd1);
    chk("lost_locked", 64'(locked), 64'd0);
    chk("lost_out", 64'(out_data), 64'h06050403);

    // Idle gaps between beats change nothing.
    for (int i = 0; i < NCH; i++) begin
      beat(WIDTH'(8'h10 + i), (i == 0));
      idle($urandom_range(0, 3));
    end
    chk("gap_data", 64'(out_data), 64'h13121110);

    // Reset mid-frame, with a simultaneous beat that must lose.
    beat(8'h20, 1'b1);
    beat(8'h21, 1'b0);
    do_reset(1'b1);
    idle(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        beat(WIDTH'($urandom), ($urandom_range(0, 5) == 0) || (!locked_m && $urandom_range(0, 1) == 1));
      end
      gaps = $urandom_range(0, 2);
      idle(gaps);
    end

`ifdef DEMUX_TDM_ERRCNT_EN
    do_reset(1'b0);
    beat(8'h00, 1'b1);
    for (int i = 0; i < 260; i++) beat(WIDTH'(i), 1'b1);
    chk("err_count_sat", 64'(err_count), 64'(err_total));
    chk("err_count_255", 64'(err_count), 64'd255);
`endif

    idle(4);
    chk("frames_left", 64'(frame_q.size()), 64'd0);
    chk("errs_left", 64'(err_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
